// File: rtl/wb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_regfile                                                 |
// | Description : Write-back stage and 32x32 GPR file. Bypassed read ports,  |
// |               forwarding bus, retired-write counter.                     |
// |               Optional debug read port: WB_REGFILE_DEBUG_EN.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              in_clk,
  input  logic              in_rst,
`ifdef WB_REGFILE_DEBUG_EN
  input  logic [ADDR_W-1:0] in_dbg_raddr,
  output logic [DATA_W-1:0] out_dbg_rdata,
`endif
  input  logic [ADDR_W-1:0] in_rd_waddr,
  input  logic              in_rd_wena,
  input  logic              in_rd_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_dmem_data,
  input  logic [ADDR_W-1:0] in_rs_raddr,
  input  logic [ADDR_W-1:0] in_rt_raddr,
  output logic [DATA_W-1:0] out_rs_rdata,
  output logic [DATA_W-1:0] out_rt_rdata,
  output logic              out_wb_wena,
  output logic [ADDR_W-1:0] out_wb_waddr,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [31:0]       out_wb_count
);

  localparam int c_NUM_REGS = 2 ** ADDR_W;
`ifdef WB_REGFILE_DEBUG_EN
  localparam int c_NUM_PORTS = 3;
`else
  localparam int c_NUM_PORTS = 2;
`endif

  logic [DATA_W-1:0] r_regs [c_NUM_REGS];
  logic [31:0]       r_wb_count;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_eff_we;
  logic [ADDR_W-1:0] w_raddr [c_NUM_PORTS];
  logic [DATA_W-1:0] w_rdata [c_NUM_PORTS];

  assign w_wb_data = in_rd_sel ? in_dmem_data : in_alu_result;
  assign w_eff_we  = in_rd_wena & (in_rd_waddr != '0) & ~in_rst;

  assign out_wb_wena  = w_eff_we;
  assign out_wb_waddr = in_rd_waddr;
  assign out_wb_data  = w_wb_data;
  assign out_wb_count = r_wb_count;

  // Entry 0 is never written after reset, so it stays zero in storage too.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_count <= '0;
    end else if (w_eff_we) begin
      r_regs[in_rd_waddr] <= w_wb_data;
      r_wb_count          <= r_wb_count + 32'd1;
    end
  end

  assign w_raddr[0] = in_rs_raddr;
  assign w_raddr[1] = in_rt_raddr;
`ifdef WB_REGFILE_DEBUG_EN
  assign w_raddr[2]    = in_dbg_raddr;
  assign out_dbg_rdata = w_rdata[2];
`endif

  // Every read port shares the zero, reset-force and write-through rules.
  generate
    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_rd_port
      always_comb begin
        w_rdata[p] = r_regs[w_raddr[p]];
        if (in_rst || (w_raddr[p] == '0)) begin
          w_rdata[p] = '0;
        end else if (w_eff_we && (w_raddr[p] == in_rd_waddr)) begin
          w_rdata[p] = w_wb_data;
        end
      end
    end
  endgenerate

  assign out_rs_rdata = w_rdata[0];
  assign out_rt_rdata = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_regfile                                              |
// | Description : Self-checking bench for wb_regfile: directed table,        |
// |               randomized traffic against a reference model, wrap check.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              in_clk = 1'b0;
  logic              in_rst;
  logic [ADDR_W-1:0] in_rd_waddr;
  logic              in_rd_wena;
  logic              in_rd_sel;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_dmem_data;
  logic [ADDR_W-1:0] in_rs_raddr;
  logic [ADDR_W-1:0] in_rt_raddr;
  logic [DATA_W-1:0] out_rs_rdata;
  logic [DATA_W-1:0] out_rt_rdata;
  logic              out_wb_wena;
  logic [ADDR_W-1:0] out_wb_waddr;
  logic [DATA_W-1:0] out_wb_data;
  logic [31:0]       out_wb_count;
`ifdef WB_REGFILE_DEBUG_EN
  logic [ADDR_W-1:0] in_dbg_raddr;
  logic [DATA_W-1:0] out_dbg_rdata;
`endif

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
`ifdef WB_REGFILE_DEBUG_EN
    .in_dbg_raddr  (in_dbg_raddr),
    .out_dbg_rdata (out_dbg_rdata),
`endif
    .in_rd_waddr   (in_rd_waddr),
    .in_rd_wena    (in_rd_wena),
    .in_rd_sel     (in_rd_sel),
    .in_alu_result (in_alu_result),
    .in_dmem_data  (in_dmem_data),
    .in_rs_raddr   (in_rs_raddr),
    .in_rt_raddr   (in_rt_raddr),
    .out_rs_rdata  (out_rs_rdata),
    .out_rt_rdata  (out_rt_rdata),
    .out_wb_wena   (out_wb_wena),
    .out_wb_waddr  (out_wb_waddr),
    .out_wb_data   (out_wb_data),
    .out_wb_count  (out_wb_count)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic              rst;
    logic              wena;
    logic [ADDR_W-1:0] waddr;
    logic              sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] dmem;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] exp_rs;
    logic [DATA_W-1:0] exp_rt;
    logic              exp_wena;
    logic [DATA_W-1:0] exp_wbd;
    logic [31:0]       exp_count;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: architectural state only.
  logic [DATA_W-1:0] m_regs [32];
  logic [31:0]       m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic wena, input logic [ADDR_W-1:0] waddr,
                       input logic sel, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] dmem,
                       input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    in_rst        = rst;
    in_rd_wena    = wena;
    in_rd_waddr   = waddr;
    in_rd_sel     = sel;
    in_alu_result = alu;
    in_dmem_data  = dmem;
    in_rs_raddr   = rs;
    in_rt_raddr   = rt;
`ifdef WB_REGFILE_DEBUG_EN
    in_dbg_raddr  = rs;
`endif
  endtask

  function automatic logic [DATA_W-1:0] m_wbd();
    return in_rd_sel ? in_dmem_data : in_alu_result;
  endfunction

  function automatic logic m_we();
    return in_rd_wena && (in_rd_waddr != 0) && !in_rst;
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (in_rst || a == 0) return '0;
    if (m_we() && a == in_rd_waddr) return m_wbd();
    return m_regs[a];
  endfunction

  // Called just after the rising edge, inputs still stable.
  task automatic m_commit();
    if (in_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_count = '0;
    end else if (m_we()) begin
      m_regs[in_rd_waddr] = m_wbd();
      m_count = m_count + 32'd1;
    end
  endtask

  // Compare combinational outputs against the model, clock, compare counter.
  task automatic step_model();
    #1;
    chk("rs_rdata", out_rs_rdata, m_read(in_rs_raddr));
    chk("rt_rdata", out_rt_rdata, m_read(in_rt_raddr));
`ifdef WB_REGFILE_DEBUG_EN
    chk("dbg_rdata", out_dbg_rdata, m_read(in_dbg_raddr));
`endif
    chk("wb_wena", {31'd0, out_wb_wena}, {31'd0, m_we()});
    chk("wb_waddr", {27'd0, out_wb_waddr}, {27'd0, in_rd_waddr});
    chk("wb_data", out_wb_data, m_wbd());
    @(posedge in_clk);
    m_commit();
    #1;
    chk("wb_count", out_wb_count, m_count);
    @(negedge in_clk);
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v.rst, v.wena, v.waddr, v.sel, v.alu, v.dmem, v.rs, v.rt);
    #1;
    chk("vec_rs", out_rs_rdata, v.exp_rs);
    chk("vec_rt", out_rt_rdata, v.exp_rt);
    chk("vec_wena", {31'd0, out_wb_wena}, {31'd0, v.exp_wena});
    chk("vec_waddr", {27'd0, out_wb_waddr}, {27'd0, v.waddr});
    chk("vec_wbd", out_wb_data, v.exp_wbd);
    @(posedge in_clk);
    m_commit();
    #1;
    chk("vec_count", out_wb_count, v.exp_count);
    @(negedge in_clk);
  endtask

  vec_t tbl [9];

  initial begin
    //        rst   wena  waddr sel   alu           dmem          rs    rt    exp_rs        exp_rt        ewe   exp_wbd       count
    tbl[0] = '{1'b0, 1'b1, 5'd5, 1'b0, 32'h12345678, 32'h0,        5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b1, 32'h12345678, 32'd1};
    tbl[1] = '{1'b0, 1'b0, 5'd5, 1'b0, 32'h0,        32'h0,        5'd5, 5'd0, 32'h12345678, 32'h0,        1'b0, 32'h0,        32'd1};
    tbl[2] = '{1'b0, 1'b1, 5'd7, 1'b1, 32'h1,        32'hDEADBEEF, 5'd7, 5'd5, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'd2};
    tbl[3] = '{1'b0, 1'b1, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h0,        5'd0, 5'd7, 32'h0,        32'hDEADBEEF, 1'b0, 32'hFFFFFFFF, 32'd2};
    tbl[4] = '{1'b0, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd7, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        32'd2};
    tbl[5] = '{1'b0, 1'b1, 5'd9, 1'b0, 32'hA5A5A5A5, 32'h0,        5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 32'd3};
    tbl[6] = '{1'b1, 1'b1, 5'd9, 1'b0, 32'h5,        32'h0,        5'd9, 5'd7, 32'h0,        32'h0,        1'b0, 32'h5,        32'd0};
    tbl[7] = '{1'b0, 1'b1, 5'd9, 1'b0, 32'h77,       32'h0,        5'd9, 5'd7, 32'h77,       32'h0,        1'b1, 32'h77,       32'd1};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        5'd9, 5'd3, 32'h77,       32'h0,        1'b0, 32'h0,        32'd1};

    for (int i = 0; i < 32; i++) m_regs[i] = 'x;
    m_count = 'x;

    // Reset for two cycles with a pending write that must be dropped.
    @(negedge in_clk);
    drive(1'b1, 1'b1, 5'd4, 1'b0, 32'h11, 32'h22, 5'd4, 5'd4);
    step_model();
    step_model();

    // Every address reads zero on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, a[4:0], 5'(31 - a));
      #1;
      chk("post_rst_rs", out_rs_rdata, 32'h0);
      chk("post_rst_rt", out_rt_rdata, 32'h0);
      @(negedge in_clk);
    end
    chk("post_rst_count", out_wb_count, 32'h0);

    for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0),
            wa,
            1'($urandom),
            $urandom,
            $urandom,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      step_model();
    end

    // Counter wrap: preset the counter to all ones, then one write to r3.
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd0);
    force dut.r_wb_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wb_count;
    m_count = 32'hFFFFFFFF;
    #1;
    chk("count_preset", out_wb_count, 32'hFFFFFFFF);
    @(negedge in_clk);
    drive(1'b0, 1'b1, 5'd3, 1'b0, 32'h0BADCAFE, 32'h0, 5'd3, 5'd3);
    step_model();
    chk("count_wrapped", out_wb_count, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd0);
    #1;
    chk("r3_after_wrap", out_rs_rdata, 32'h0BADCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural register file.
- Selects the write-back data (ALU result or data-memory load) and commits it to the 32x32 GPR array.
- Provides the two ID-stage read ports with same-cycle write-through bypass, and exports the write-back bus for EX forwarding.
- Keeps a retired-write counter.

Parameters:
- DATA_W, 32, register and bus width.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst  input  1  reset; synchronous, active-high.
- in_rd_waddr  input  ADDR_W  destination register from MEM/WB.
- in_rd_wena  input  1  write enable from MEM/WB.
- in_rd_sel  input  1  write-back source: 1 = in_dmem_data, 0 = in_alu_result.
- in_alu_result  input  DATA_W  ALU result from MEM/WB.
- in_dmem_data  input  DATA_W  load data from MEM/WB.
- in_rs_raddr  input  ADDR_W  read port A address (ID stage).
- in_rt_raddr  input  ADDR_W  read port B address (ID stage).
- out_rs_rdata  output  DATA_W  read port A data, combinational.
- out_rt_rdata  output  DATA_W  read port B data, combinational.
- out_wb_wena  output  1  effective write enable, for forwarding.
- out_wb_waddr  output  ADDR_W  write-back address, for forwarding.
- out_wb_data  output  DATA_W  muxed write-back data, for forwarding.
- out_wb_count  output  32  count of committed register writes, registered.

Behaviour:
- Write-back data: wb_data = in_rd_sel ? in_dmem_data : in_alu_result. Combinational, zero latency.
- Effective enable: eff_we = in_rd_wena & (in_rd_waddr != 0) & ~in_rst.
- out_wb_wena = eff_we; out_wb_waddr = in_rd_waddr; out_wb_data = wb_data.
- Commit: on a rising edge with eff_we = 1, regs[in_rd_waddr] <= wb_data. The write is visible in storage from the next cycle.
- Register 0: hardwired zero. Writes to it are dropped and not counted; reads always return 0.
- Read port (each port identical):
  - address 0 -> 0.
  - else if eff_we and address == in_rd_waddr -> wb_data (bypass).
  - else -> regs[address].
- Both ports may hit the same register, including the bypassed one; both then return the same value.
- Counter: out_wb_count increments by 1 on each edge with eff_we = 1. It wraps from 0xFFFFFFFF to 0 with no flag.
- Reset (in_rst = 1 at a rising edge):
  - all 32 registers <= 0; out_wb_count <= 0.
  - reset dominates a simultaneous write; the write is lost and not counted.
- While in_rst = 1:
  - out_rs_rdata, out_rt_rdata, out_wb_wena are forced to 0.
  - out_wb_waddr and out_wb_data still pass through.
- Reset asserted mid-stream: state is cleared at that edge. Writes presented on the first cycle after reset deassertion are committed normally.
- No X propagation: registers and counter are always defined after the first reset edge.
- No stall or flush inputs. MEM/WB squashes an instruction by driving in_rd_wena = 0.

Optional Feature:
- Macro: WB_REGFILE_DEBUG_EN.
- Defined:
  - adds ports in_dbg_raddr (input, ADDR_W) and out_dbg_rdata (output, DATA_W).
  - out_dbg_rdata is a third combinational read port with identical zero, bypass and reset-force rules.
- Undefined: the ports are absent and there is no extra read logic.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> all reads 0; out_wb_count = 0.
2. wena=1, waddr=5, sel=0, alu=0x12345678, rs_raddr=5 in the same cycle -> out_rs_rdata = 0x12345678 before the edge (bypass). The next cycle, with wena=0, still reads 0x12345678; count = 1.
3. wena=1, waddr=7, sel=1, dmem=0xDEADBEEF, alu=0x1 -> regs[7] = 0xDEADBEEF; out_wb_data = 0xDEADBEEF.
4. wena=1, waddr=0, alu=0xFFFFFFFF -> rs_raddr=0 reads 0 in the same and following cycles; out_wb_wena = 0; count unchanged.
5. Write 0xA5A5A5A5 to r9, then assert rst with a simultaneous wena=1, waddr=9, alu=0x5 -> after the edge r9 = 0 and count = 0. Reads are forced to 0 while rst is high.
6. Preload the counter path with 2^32-1 writes (or force the counter to 0xFFFFFFFF), then one write to r3 -> out_wb_count = 0.
